// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray-code receiver: state encodings, default
// widths and a Gray-to-binary helper.
`default_nettype none

package gray_decoder_pkg;

    localparam int DEFAULT_WIDTH  = 3;
    localparam int DEFAULT_WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_RESYNC   = 2'b10
    } state_e;

    // Converts the low 'width' bits of g; bits above 'width' must be zero.
    function automatic logic [31:0] g2b(input logic [31:0] g, input int unsigned width);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage : gray_decoder_pkg

`default_nettype wire

// File: rtl/gray_decoder_gray2bin.sv
// Parameterised combinational Gray-to-binary converter.
`default_nettype none

module gray_decoder_gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_binary[i] = ^i_gray[WIDTH-1:i];
    end

endmodule : gray_decoder_gray2bin

`default_nettype wire

// File: rtl/gray_decoder.sv
// Gray-code bus receiver: converts to binary, checks single-step forward
// progress, reports wraps and illegal transitions, re-locks automatically.
`default_nettype none

module gray_decoder
    import gray_decoder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int WRAP_W = DEFAULT_WRAP_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  GrayIn,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Binary,
    output logic              Locked,
    output logic              Overflow,
    output logic              Error,
    output logic              ErrSticky,
    output logic [WRAP_W-1:0] WrapCount
);

    localparam logic [WIDTH-1:0]  C_BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] C_WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_e              state_q,      state_d;
    logic [WIDTH-1:0]    binary_q,     binary_d;
    logic                overflow_q,   overflow_d;
    logic                error_q,      error_d;
    logic                err_sticky_q, err_sticky_d;
    logic [WRAP_W-1:0]   wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]    w_sample_bin;
    logic [WIDTH-1:0]    w_next_expected;
    logic                w_is_step;
    logic                w_is_hold;
    logic                w_at_max;
    logic                w_wrap_event;

    gray_decoder_gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .i_gray   (GrayIn),
        .o_binary (w_sample_bin)
    );

    assign w_next_expected = binary_q + C_BIN_ONE;
    assign w_is_step       = (w_sample_bin == w_next_expected);
    assign w_is_hold       = (w_sample_bin == binary_q);
    assign w_at_max        = &binary_q;

    always_comb begin
        state_d      = state_q;
        binary_d     = binary_q;
        overflow_d   = 1'b0;
        error_d      = 1'b0;
        w_wrap_event = 1'b0;

        case (state_q)
            ST_UNLOCKED: begin
                if (Valid) begin
                    binary_d = w_sample_bin;
                    state_d  = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (Valid && !w_is_hold) begin
                    binary_d = w_sample_bin;
                    if (w_is_step) begin
                        if (w_at_max) begin
                            overflow_d   = 1'b1;
                            w_wrap_event = 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_RESYNC;
                    end
                end
            end
            ST_RESYNC: begin
                // Only the first illegal step pulses Error; stay here until a clean step.
                if (Valid && !w_is_hold) begin
                    binary_d = w_sample_bin;
                    if (w_is_step) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        wrap_count_d = wrap_count_q;

        // Clear beats a same-cycle wrap, but a same-cycle Error still sets the sticky bit.
        if (Clear) begin
            err_sticky_d = 1'b0;
            wrap_count_d = '0;
        end else if (w_wrap_event && !(&wrap_count_q)) begin
            wrap_count_d = wrap_count_q + C_WRAP_ONE;
        end

        if (error_d) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_UNLOCKED;
            binary_q     <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            binary_q     <= binary_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
            err_sticky_q <= err_sticky_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign Binary    = binary_q;
    assign Locked    = (state_q == ST_LOCKED);
    assign Overflow  = overflow_q;
    assign Error     = error_q;
    assign ErrSticky = err_sticky_q;
    assign WrapCount = wrap_count_q;

endmodule : gray_decoder

`default_nettype wire

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: directed vectors push expected results,
// a negedge monitor pops and compares them.
`default_nettype none

module tb_gray_decoder;

    typedef struct packed {
        logic [2:0] b;
        logic       l;
        logic       o;
        logic       e;
        logic       s;
        logic [1:0] w;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic [2:0] GrayIn = 3'b000;
    logic       Clear = 1'b0;
    logic [2:0] Binary;
    logic       Locked;
    logic       Overflow;
    logic       Error;
    logic       ErrSticky;
    logic [1:0] WrapCount;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    gray_decoder #(
        .WIDTH  (3),
        .WRAP_W (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Valid     (Valid),
        .GrayIn    (GrayIn),
        .Clear     (Clear),
        .Binary    (Binary),
        .Locked    (Locked),
        .Overflow  (Overflow),
        .Error     (Error),
        .ErrSticky (ErrSticky),
        .WrapCount (WrapCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".Binary"},    int'(Binary),    int'(e.b));
        chk({tag, ".Locked"},    int'(Locked),    int'(e.l));
        chk({tag, ".Overflow"},  int'(Overflow),  int'(e.o));
        chk({tag, ".Error"},     int'(Error),     int'(e.e));
        chk({tag, ".ErrSticky"}, int'(ErrSticky), int'(e.s));
        chk({tag, ".WrapCount"}, int'(WrapCount), int'(e.w));
    endtask

    // Monitor: outputs after each sampling edge are compared on the following negedge.
    always @(negedge Clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk_all("sb", e);
        end
    end

    task automatic drv(input logic v, input logic [2:0] g, input logic clr,
                       input logic [2:0] eb, input logic el, input logic eo,
                       input logic ee, input logic es, input logic [1:0] ew);
        exp_t e;
        Valid  = v;
        GrayIn = g;
        Clear  = clr;
        @(posedge Clk);
        #1;
        e = '{b: eb, l: el, o: eo, e: ee, s: es, w: ew};
        sb_q.push_back(e);
    endtask

    // Gray codes of binary 0..7.
    logic [2:0] gray_of [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        exp_t r;
        logic [1:0] w_prev;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        r = '{b: 3'd0, l: 1'b0, o: 1'b0, e: 1'b0, s: 1'b0, w: 2'd0};
        chk_all("reset", r);
        Reset = 1'b1;

        // Idle Valid=0 stays unlocked
        drv(0, 3'b111, 0, 3'd0, 0, 0, 0, 0, 2'd0);

        // Test 1: full count with one wrap
        drv(1, 3'b000, 0, 3'd0, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b001, 0, 3'd1, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b011, 0, 3'd2, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b010, 0, 3'd3, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b110, 0, 3'd4, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b111, 0, 3'd5, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b101, 0, 3'd6, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b100, 0, 3'd7, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b000, 0, 3'd0, 1, 1, 0, 0, 2'd1);

        // Test 2: hold and Valid=0 at binary 2
        drv(1, 3'b001, 0, 3'd1, 1, 0, 0, 0, 2'd1);
        drv(1, 3'b011, 0, 3'd2, 1, 0, 0, 0, 2'd1);
        repeat (5) drv(1, 3'b011, 0, 3'd2, 1, 0, 0, 0, 2'd1);
        repeat (3) drv(0, 3'b111, 0, 3'd2, 1, 0, 0, 0, 2'd1);

        // Test 3: forward jump 2 -> 5, then clean step re-locks
        drv(1, 3'b111, 0, 3'd5, 0, 0, 1, 1, 2'd1);
        drv(1, 3'b101, 0, 3'd6, 1, 0, 0, 1, 2'd1);
        drv(1, 3'b100, 0, 3'd7, 1, 0, 0, 1, 2'd1);

        // Test 4: backward step, re-lock, then Clear
        drv(1, 3'b000, 0, 3'd0, 1, 1, 0, 1, 2'd2);
        drv(1, 3'b001, 0, 3'd1, 1, 0, 0, 1, 2'd2);
        drv(1, 3'b011, 0, 3'd2, 1, 0, 0, 1, 2'd2);
        drv(1, 3'b001, 0, 3'd1, 0, 0, 1, 1, 2'd2);
        drv(1, 3'b011, 0, 3'd2, 1, 0, 0, 1, 2'd2);
        drv(0, 3'b011, 1, 3'd2, 1, 0, 0, 0, 2'd0);

        // Test 5: five wraps with 2-bit saturating counter
        for (int i = 3; i < 8; i++)
            drv(1, gray_of[i], 0, 3'(i), 1, 0, 0, 0, 2'd0);
        drv(1, 3'b000, 0, 3'd0, 1, 1, 0, 0, wrap_exp[0]);
        for (int k = 1; k < 5; k++) begin
            w_prev = wrap_exp[k-1];
            for (int i = 1; i < 8; i++)
                drv(1, gray_of[i], 0, 3'(i), 1, 0, 0, 0, w_prev);
            drv(1, 3'b000, 0, 3'd0, 1, 1, 0, 0, wrap_exp[k]);
        end

        // Clear in the same cycle as a wrap: Overflow pulses, count not taken
        for (int i = 1; i < 8; i++)
            drv(1, gray_of[i], 0, 3'(i), 1, 0, 0, 0, 2'd3);
        drv(1, 3'b000, 1, 3'd0, 1, 1, 0, 0, 2'd0);
        drv(0, 3'b000, 0, 3'd0, 1, 0, 0, 0, 2'd0);

        // Error with Clear in the same cycle: sticky set wins
        drv(1, 3'b101, 1, 3'd6, 0, 0, 1, 1, 2'd0);
        drv(1, 3'b100, 0, 3'd7, 1, 0, 0, 1, 2'd0);

        // RESYNC: further jumps and holds do not pulse Error
        drv(1, 3'b011, 0, 3'd2, 0, 0, 1, 1, 2'd0);
        drv(1, 3'b110, 0, 3'd4, 0, 0, 0, 1, 2'd0);
        drv(1, 3'b110, 0, 3'd4, 0, 0, 0, 1, 2'd0);
        drv(1, 3'b111, 0, 3'd5, 1, 0, 0, 1, 2'd0);

        // Wrap accepted in RESYNC: no Overflow, no count
        drv(1, 3'b100, 0, 3'd7, 0, 0, 1, 1, 2'd0);
        drv(1, 3'b000, 0, 3'd0, 1, 0, 0, 1, 2'd0);

        // Test 6: asynchronous reset mid-sequence at binary 6
        for (int i = 1; i < 7; i++)
            drv(1, gray_of[i], 0, 3'(i), 1, 0, 0, 1, 2'd0);
        Valid = 1'b0;
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        r = '{b: 3'd0, l: 1'b0, o: 1'b0, e: 1'b0, s: 1'b0, w: 2'd0};
        chk_all("async_rst", r);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        drv(1, 3'b110, 0, 3'd4, 1, 0, 0, 0, 2'd0);
        drv(1, 3'b111, 0, 3'd5, 1, 0, 0, 0, 2'd0);

        Valid = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gray_decoder

`default_nettype wire
